// File: rtl/syn_rx.sv
// syn_rx: slave receiver for the one-wire second-sync frame (start=1, DATA_BITS MSB first, stop=0).
// Latency: rx_valid/frame_err pulse 50 clk_10M cycles after syn_in rises (51 with SYN_RX_MAJORITY_EN).
// No backpressure: each result is a one-cycle strobe; SYN_RX_MAJORITY_EN enables a 2-of-3 vote per sample.
module syn_rx #(
  parameter int BIT_CLKS   = 5,
  parameter int SAMPLE_OFS = 2,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_10M,
  input  logic                 rst,
  input  logic                 syn_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int PW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);
`ifdef SYN_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so decide one phase later.
  localparam int DEC_OFS = SAMPLE_OFS + 1;
`else
  localparam int DEC_OFS = SAMPLE_OFS;
`endif
  localparam logic [PW-1:0] DEC_PH   = PW'(DEC_OFS);
  localparam logic [PW-1:0] LAST_PH  = PW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic                   sync_q;
  logic                   rx_s;
  logic                   rx_d;
`ifdef SYN_RX_MAJORITY_EN
  logic                   rx_dd;
`endif
  logic                   armed;
  logic [PW-1:0]          phase;
  logic [PW-1:0]          phase_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   smp_evt;
  logic                   smp_bit;
  logic                   wrap;
  logic                   data_done;

  // Two-flop synchroniser, then delay taps used for edge detection and voting
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      sync_q <= 1'b0;
      rx_s   <= 1'b0;
      rx_d   <= 1'b0;
`ifdef SYN_RX_MAJORITY_EN
      rx_dd  <= 1'b0;
`endif
    end else begin
      sync_q <= syn_in;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
`ifdef SYN_RX_MAJORITY_EN
      rx_dd  <= rx_d;
`endif
    end
  end

  // Slot timing qualifiers and the bit value taken at each sample event
  always_comb begin
    wrap      = (phase == LAST_PH);
    phase_nxt = wrap ? '0 : phase + PW'(1);
    smp_evt   = (phase == DEC_PH);
`ifdef SYN_RX_MAJORITY_EN
    // rx_dd/rx_d/rx_s hold the line at SAMPLE_OFS-1, SAMPLE_OFS, SAMPLE_OFS+1
    smp_bit   = (rx_s & rx_d) | (rx_s & rx_dd) | (rx_d & rx_dd);
`else
    smp_bit   = rx_s;
`endif
    // Last payload bit may be taken on the same cycle as the slot wrap
    data_done = (bit_cnt == ALL_BITS) || (smp_evt && (bit_cnt == LAST_BIT));
  end

  // Frame FSM: armed edge detect, per-slot sampling, shift-in and result strobes
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // A rise only counts once the line has been seen low while idle
          if (!rx_s) armed <= 1'b1;
          if (armed && rx_s && !rx_d) begin
            state   <= START;
            phase   <= PW'(1);
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          phase <= phase_nxt;
          if (smp_evt && !smp_bit) begin
            state <= IDLE;
            armed <= 1'b0;
            busy  <= 1'b0;
            phase <= '0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          phase <= phase_nxt;
          if (smp_evt) begin
            shreg   <= {shreg[DATA_BITS-2:0], smp_bit};
            bit_cnt <= bit_cnt + CW'(1);
          end
          if (wrap && data_done) state <= STOP;
        end
        STOP: begin
          phase <= phase_nxt;
          if (smp_evt) begin
            if (smp_bit) begin
              frame_err <= 1'b1;
            end else begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
            state <= IDLE;
            armed <= 1'b0;
            busy  <= 1'b0;
            phase <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
